// File: rtl/gray_ptr_sync_cvt.sv
// gray_ptr_sync_cvt
//
// Destination-side receiver for a Gray-coded FIFO pointer crossing into the
// i_clk domain. The pointer passes through a SYNC_STAGES-deep synchronizer,
// is converted to binary in a registered stage, and the per-cycle advance
// (delta) of the binary pointer is reported alongside it.
//
// Optional feature (macro GRAY_PTR_SYNC_CHK_EN): sticky flag that sets when
// two consecutive synchronized Gray values differ in more than one bit.
// With the macro undefined, o_gray_err is tied low and no checker is built.
//
// Ports:
//   i_clk       destination clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_ptr_gray  Gray pointer from the foreign domain (asynchronous)
//   o_ptr_gray  synchronized Gray pointer (last synchronizer stage)
//   o_ptr_bin   registered binary equivalent of o_ptr_gray
//   o_valid     high once the pipeline is primed after reset
//   o_delta     (o_ptr_bin - previous o_ptr_bin) mod 2^WIDTH
//   o_adv       high when o_delta is non-zero
//   o_gray_err  sticky Gray-protocol violation flag

module gray_ptr_sync_cvt #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_ptr_gray,
  output logic [WIDTH-1:0] o_ptr_gray,
  output logic [WIDTH-1:0] o_ptr_bin,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_delta,
  output logic             o_adv,
  output logic             o_gray_err
);

  localparam int unsigned CNT_MAX = SYNC_STAGES + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // Synchronizer: index 0 is the first (metastable) stage. Pure shift, no logic.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_sync_gray;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ptr_gray};
    end
  end

  assign w_sync_gray = r_sync[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  logic [WIDTH-1:0] w_bin;

  always_comb begin : p_g2b
    logic acc;
    acc   = 1'b0;
    w_bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc      = acc ^ w_sync_gray[i];
      w_bin[i] = acc;
    end
  end

  // Prime counter: saturates at SYNC_STAGES+1; o_valid sets on that edge.
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_cnt != CNT_W'(CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_cnt == CNT_W'(SYNC_STAGES)) begin
        r_valid <= 1'b1;
      end
    end
  end

  // r_bin is the previous binary value at the moment the next one is loaded, so
  // it doubles as the delta baseline. Delta is forced to zero until the cycle
  // after o_valid rises, which makes the first valid value the baseline.
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_delta;
  logic             r_adv;
  logic [WIDTH-1:0] w_delta;

  assign w_delta = w_bin - r_bin;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin   <= '0;
      r_delta <= '0;
      r_adv   <= 1'b0;
    end else begin
      r_bin   <= w_bin;
      r_delta <= r_valid ? w_delta : '0;
      r_adv   <= r_valid && (w_delta != '0);
    end
  end

`ifdef GRAY_PTR_SYNC_CHK_EN
  // Gray history aligned with r_bin so a bad step flags one edge after the
  // o_delta that reports it. r_base masks the first valid (baseline) cycle.
  logic [WIDTH-1:0] r_gray_d1;
  logic [WIDTH-1:0] r_gray_d2;
  logic [WIDTH-1:0] w_gray_diff;
  logic             w_multi_bit;
  logic             r_base;
  logic             r_err;

  assign w_gray_diff = r_gray_d1 ^ r_gray_d2;
  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign w_multi_bit = (w_gray_diff & (w_gray_diff - WIDTH'(1))) != '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gray_d1 <= '0;
      r_gray_d2 <= '0;
      r_base    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_gray_d1 <= w_sync_gray;
      r_gray_d2 <= r_gray_d1;
      r_base    <= r_valid;
      if (r_valid && r_base && w_multi_bit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_gray_err = r_err;
`else
  assign o_gray_err = 1'b0;
`endif

  assign o_ptr_gray = w_sync_gray;
  assign o_ptr_bin  = r_bin;
  assign o_valid    = r_valid;
  assign o_delta    = r_delta;
  assign o_adv      = r_adv;

endmodule

// File: tb/tb_gray_ptr_sync_cvt.sv
// Self-checking bench for gray_ptr_sync_cvt. Two instances (SYNC_STAGES = 2
// and 3) share stimulus; a history-based reference model predicts every
// output after every edge, and table/hand sequences check the named corners.

module tb_gray_ptr_sync_cvt;

`ifdef GRAY_PTR_SYNC_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gin;

  logic [3:0] g2, b2, d2;
  logic       v2, a2, e2;
  logic [3:0] g3, b3, d3;
  logic       v3, a3, e3;

  gray_ptr_sync_cvt #(.WIDTH(4), .SYNC_STAGES(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_ptr_gray(gin),
    .o_ptr_gray(g2), .o_ptr_bin(b2), .o_valid(v2),
    .o_delta(d2), .o_adv(a2), .o_gray_err(e2)
  );

  gray_ptr_sync_cvt #(.WIDTH(4), .SYNC_STAGES(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_ptr_gray(gin),
    .o_ptr_gray(g3), .o_ptr_bin(b3), .o_valid(v3),
    .o_delta(d3), .o_adv(a3), .o_gray_err(e3)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         n      = 0;          // edges since reset release
  logic [3:0] hist [0:4095];       // input value seen at each edge
  logic       err_exp2, err_exp3;
  int         dsum;

  typedef struct {
    logic [3:0] gray;
    logic [3:0] bin;
    logic [3:0] delta;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  // Binary value of a Gray code: XOR of the code with all its right shifts.
  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b = 4'd0;
    for (int s = 0; s < 4; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [3:0] hv(input int e);
    return (e >= 1) ? hist[e] : 4'd0;
  endfunction

  function automatic int popc(input logic [3:0] x);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) c += int'(x[i]);
    return c;
  endfunction

  function automatic logic [3:0] m_gray(input int s, input int e);
    return hv(e - s + 1);
  endfunction

  function automatic logic [3:0] m_bin(input int s, input int e);
    return g2b(hv(e - s));
  endfunction

  function automatic logic [3:0] m_delta(input int s, input int e);
    return (e >= s + 2) ? m_bin(s, e) - m_bin(s, e - 1) : 4'd0;
  endfunction

  // A step is bad when consecutive binary-aligned Gray values differ in >1 bit.
  function automatic logic m_bad(input int s, input int e);
    return (e >= s + 2) && (popc(hv(e - s) ^ hv(e - s - 1)) > 1);
  endfunction

  task automatic check_dut(input int s, input string tag,
                           input logic [3:0] g, input logic [3:0] b, input logic [3:0] d,
                           input logic v, input logic a, input logic e, input logic ee);
    chk({tag, "_gray"},  g, m_gray(s, n));
    chk({tag, "_bin"},   b, m_bin(s, n));
    chk({tag, "_valid"}, v, n >= s + 1);
    chk({tag, "_delta"}, d, m_delta(s, n));
    chk({tag, "_adv"},   a, m_delta(s, n) != 4'd0);
    chk({tag, "_err"},   e, ee);
  endtask

  task automatic check_all(input string tag);
    check_dut(2, {tag, "2"}, g2, b2, d2, v2, a2, e2, err_exp2);
    check_dut(3, {tag, "3"}, g3, b3, d3, v3, a3, e3, err_exp3);
  endtask

  task automatic step();
    @(posedge clk);
    if (n >= 4000) begin
      $display("FAIL history_overflow: got %0d expected below 4000", n);
      $fatal(1, "history overflow");
    end
    n++;
    hist[n] = gin;
    if (ChkEn && m_bad(2, n - 1)) err_exp2 = 1'b1;
    if (ChkEn && m_bad(3, n - 1)) err_exp3 = 1'b1;
    #1;
    check_all("model");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    n        = 0;
    err_exp2 = 1'b0;
    err_exp3 = 1'b0;
    check_all("rst");
    #1;
    rst = 1'b0;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] cur_bin;
    logic [3:0] v;

    tbl[0] = '{gray: 4'b0111, bin: 4'd5,  delta: 4'd1};
    tbl[1] = '{gray: 4'b1000, bin: 4'd15, delta: 4'd10};
    tbl[2] = '{gray: 4'b0000, bin: 4'd0,  delta: 4'd1};
    tbl[3] = '{gray: 4'b0011, bin: 4'd2,  delta: 4'd2};
    tbl[4] = '{gray: 4'b0010, bin: 4'd3,  delta: 4'd1};
    tbl[5] = '{gray: 4'b0110, bin: 4'd4,  delta: 4'd1};

    rst      = 1'b1;
    gin      = 4'd0;
    err_exp2 = 1'b0;
    err_exp3 = 1'b0;
    #2;
    check_all("por");
    rst = 1'b0;

    // Run a little, then reset mid-operation with 0110 on the input.
    for (int i = 0; i < 6; i++) begin
      step();
      gin = 4'($urandom_range(0, 15));
    end
    gin = 4'b0110;
    step();
    do_reset();

    // Prime sequence: valid on 3rd edge (S=2) and 4th edge (S=3).
    step();
    chk("prime_v2_e1", v2, 1'b0);
    step();
    chk("prime_v2_e2", v2, 1'b0);
    step();
    chk("prime_v2_e3", v2, 1'b1);
    chk("prime_b2_e3", b2, 4'd4);
    chk("prime_d2_e3", d2, 4'd0);
    chk("prime_a2_e3", a2, 1'b0);
    chk("prime_v3_e3", v3, 1'b0);
    step();
    chk("prime_v3_e4", v3, 1'b1);
    chk("prime_b3_e4", b3, 4'd4);
    chk("prime_d3_e4", d3, 4'd0);
    steps(2);

    // Table: step, wrap, jumps; 3-edge latency on S=2, 4-edge on S=3.
    prev = 4'd4;
    for (int i = 0; i < 6; i++) begin
      gin = tbl[i].gray;
      steps(3);
      chk($sformatf("tbl%0d_bin2", i),   b2, tbl[i].bin);
      chk($sformatf("tbl%0d_delta2", i), d2, tbl[i].delta);
      chk($sformatf("tbl%0d_adv2", i),   a2, 1'b1);
      chk($sformatf("tbl%0d_bin3_old", i), b3, prev);
      step();
      chk($sformatf("tbl%0d_bin3", i),   b3, tbl[i].bin);
      chk($sformatf("tbl%0d_delta3", i), d3, tbl[i].delta);
      chk($sformatf("tbl%0d_delta2_z", i), d2, 4'd0);
      chk($sformatf("tbl%0d_adv2_z", i),   a2, 1'b0);
      steps(2);
      prev = tbl[i].bin;
    end

    // Multi-step jump 0 -> 2: delta 2 now, sticky error one edge later.
    gin = 4'b0000;
    step();
    do_reset();
    steps(6);
    gin = 4'b0011;
    steps(3);
    chk("jump_delta2", d2, 4'd2);
    chk("jump_adv2", a2, 1'b1);
    chk("jump_err2_early", e2, 1'b0);
    step();
    chk("jump_err2", e2, ChkEn);
    steps(10);
    chk("jump_err2_hold", e2, ChkEn);
    chk("jump_err3_hold", e3, ChkEn);
    do_reset();
    chk("jump_err2_clr", e2, 1'b0);

    // Steady stream: +1 every 2 cycles for 40 steps from 0.
    gin = 4'b0000;
    steps(6);
    dsum = 0;
    for (int i = 1; i <= 40; i++) begin
      v   = 4'(i);
      gin = v ^ (v >> 1);
      step();
      dsum += int'(d2);
      step();
      dsum += int'(d2);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      dsum += int'(d2);
    end
    chk("stream_sum", 32'(dsum % 16), 32'd8);
    chk("stream_bin", b2, 4'd8);
    chk("stream_err", e2, 1'b0);

    // Random: mostly single steps, sometimes arbitrary jumps, random hold.
    cur_bin = 4'd8;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) cur_bin = cur_bin + 4'd1;
      else cur_bin = 4'($urandom_range(0, 15));
      gin = cur_bin ^ (cur_bin >> 1);
      steps($urandom_range(1, 3));
    end
    steps(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
